// File: rtl/trq_pkg.sv
// Shared types for the trace request queue: memop commands, FSM states and the
// queue entry. Entry fields are sized for the widest supported configuration.
package trq_pkg;

  localparam int TS_MAX_W   = 64;
  localparam int ADDR_MAX_W = 64;

  typedef enum logic [1:0] {
    CMD_READ   = 2'd0,
    CMD_WRITE  = 2'd1,
    CMD_IFETCH = 2'd2
  } cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ISSUE,
    ST_HALT
  } state_e;

  typedef struct packed {
    logic [TS_MAX_W-1:0]   ts;
    cmd_e                  cmd;
    logic [ADDR_MAX_W-1:0] addr;
  } entry_t;

endpackage

// File: rtl/trq_fifo.sv
// Circular entry store with wrap-around pointers and an occupancy count.
// Exposes the head and the entry behind it so the issuer can chain pops.
module trq_fifo
  import trq_pkg::*;
#(
  parameter  int DEPTH = 16,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  entry_t           wdata,
  output entry_t           head,
  output entry_t           second,
  output logic [CNT_W-1:0] count
);

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= wdata;
  end

  assign head   = mem[rd_ptr];
  assign second = mem[rd_ptr + PTR_W'(1)];

endmodule

// File: rtl/trace_req_queue.sv
// Timestamped trace request queue: entries are held until the cycle counter
// reaches their timestamp, then presented to the memory controller in order.
module trace_req_queue #(
  parameter  int ADDR_WIDTH = 36,
  parameter  int CMD_WIDTH  = 2,
  parameter  int TIME_WIDTH = 32,
  parameter  int DEPTH      = 16,
  parameter  int SKIP_IDLE  = 0,
  localparam int LVL_W      = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [TIME_WIDTH-1:0] in_time,
  input  logic [CMD_WIDTH-1:0]  in_cmd,
  input  logic [ADDR_WIDTH-1:0] in_addr,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [TIME_WIDTH-1:0] out_time,
  output logic [CMD_WIDTH-1:0]  out_cmd,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic [TIME_WIDTH-1:0] cycle,
  input  logic                  stop,
  output logic [LVL_W-1:0]      level,
  output logic                  idle,
  output logic                  cmd_err,
  output logic                  order_err
);
  import trq_pkg::*;

  state_e                state, state_nxt;
  entry_t                head, second, in_entry, cand;
  logic                  push, store, pop, cmd_ok;
  logic                  cand_vld, cand_elig, load_out;
  logic [TIME_WIDTH-1:0] head_ts, cand_ts, last_time;
  logic [TIME_WIDTH:0]   cyc_p1;
  logic                  unused_hi;

  trq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .push   (store),
    .pop    (pop),
    .flush  (stop),
    .wdata  (in_entry),
    .head   (head),
    .second (second),
    .count  (level)
  );

  // A full queue still accepts a push when the head leaves on the same edge.
  assign out_valid = (state == ST_ISSUE);
  assign pop       = out_valid & out_ready;
  assign in_ready  = (state != ST_HALT) && ((level != LVL_W'(DEPTH)) || pop);
  assign push      = in_valid & in_ready;
  assign cmd_ok    = (in_cmd < CMD_WIDTH'(3));
  assign store     = push & cmd_ok;
  assign idle      = (state == ST_IDLE);

  always_comb begin
    in_entry      = '0;
    in_entry.ts   = TS_MAX_W'(in_time);
    in_entry.cmd  = cmd_e'(in_cmd[1:0]);
    in_entry.addr = ADDR_MAX_W'(in_addr);
  end

  // Candidate for presentation after this edge; a freshly pushed entry must
  // first become the head, so it is never a candidate on its own push edge.
  always_comb begin
    cand     = head;
    cand_vld = (level != '0);
    if (pop) begin
      cand     = second;
      cand_vld = (level > LVL_W'(1));
    end
  end

  assign head_ts   = head.ts[TIME_WIDTH-1:0];
  assign cand_ts   = cand.ts[TIME_WIDTH-1:0];
  assign cand_elig = (cand_ts <= cycle);
  assign cyc_p1    = {1'b0, cycle} + (TIME_WIDTH + 1)'(1);
  assign unused_hi = ^{cand.ts, cand.addr};

  always_comb begin
    state_nxt = state;
    load_out  = 1'b0;
    if (state == ST_HALT) begin
      state_nxt = ST_HALT;
    end else if (stop) begin
      state_nxt = ST_HALT;
    end else if (state != ST_ISSUE || pop) begin
      if (cand_vld && cand_elig) begin
        state_nxt = ST_ISSUE;
        load_out  = 1'b1;
      end else if (store || (level > LVL_W'(pop))) begin
        state_nxt = ST_WAIT;
      end else begin
        state_nxt = ST_IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_time <= '0;
      out_cmd  <= '0;
      out_addr <= '0;
    end else if (load_out) begin
      out_time <= cand_ts;
      out_cmd  <= CMD_WIDTH'(cand.cmd);
      out_addr <= cand.addr[ADDR_WIDTH-1:0];
    end
  end

  // Counter saturates rather than wrapping so late timestamps stay eligible.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cycle <= '0;
    end else if (state == ST_HALT || stop) begin
      cycle <= cycle;
    end else if (SKIP_IDLE != 0 && state == ST_WAIT && ({1'b0, head_ts} > cyc_p1)) begin
      cycle <= head_ts;
    end else if (cycle != '1) begin
      cycle <= cyc_p1[TIME_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cmd_err   <= 1'b0;
      order_err <= 1'b0;
      last_time <= '0;
    end else begin
      if (push && !cmd_ok)                cmd_err   <= 1'b1;
      if (store && (in_time < last_time)) order_err <= 1'b1;
      if (store)                          last_time <= in_time;
    end
  end

endmodule

// File: tb/tb_trace_req_queue.sv
// Directed bench for trace_req_queue: default, SKIP_IDLE=1 and TIME_WIDTH=4
// instances share clock and reset and are exercised one after another.
module tb_trace_req_queue;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_stop;
  logic        a_idle, a_cmd_err, a_order_err;
  logic [31:0] a_in_time, a_out_time, a_cycle;
  logic [1:0]  a_in_cmd, a_out_cmd;
  logic [35:0] a_in_addr, a_out_addr;
  logic [4:0]  a_level;

  logic        s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_stop;
  logic        s_idle, s_cmd_err, s_order_err;
  logic [31:0] s_in_time, s_out_time, s_cycle;
  logic [1:0]  s_in_cmd, s_out_cmd;
  logic [35:0] s_in_addr, s_out_addr;
  logic [4:0]  s_level;

  logic        t_in_valid, t_in_ready, t_out_valid, t_out_ready, t_stop;
  logic        t_idle, t_cmd_err, t_order_err;
  logic [3:0]  t_in_time, t_out_time, t_cycle;
  logic [1:0]  t_in_cmd, t_out_cmd;
  logic [35:0] t_in_addr, t_out_addr;
  logic [4:0]  t_level;

  trace_req_queue u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_time(a_in_time), .in_cmd(a_in_cmd), .in_addr(a_in_addr),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_time(a_out_time),
    .out_cmd(a_out_cmd), .out_addr(a_out_addr), .cycle(a_cycle), .stop(a_stop),
    .level(a_level), .idle(a_idle), .cmd_err(a_cmd_err), .order_err(a_order_err)
  );

  trace_req_queue #(.SKIP_IDLE(1)) u_s (
    .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .in_time(s_in_time), .in_cmd(s_in_cmd), .in_addr(s_in_addr),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_time(s_out_time),
    .out_cmd(s_out_cmd), .out_addr(s_out_addr), .cycle(s_cycle), .stop(s_stop),
    .level(s_level), .idle(s_idle), .cmd_err(s_cmd_err), .order_err(s_order_err)
  );

  trace_req_queue #(.TIME_WIDTH(4)) u_t (
    .clk(clk), .rst_n(rst_n), .in_valid(t_in_valid), .in_ready(t_in_ready),
    .in_time(t_in_time), .in_cmd(t_in_cmd), .in_addr(t_in_addr),
    .out_valid(t_out_valid), .out_ready(t_out_ready), .out_time(t_out_time),
    .out_cmd(t_out_cmd), .out_addr(t_out_addr), .cycle(t_cycle), .stop(t_stop),
    .level(t_level), .idle(t_idle), .cmd_err(t_cmd_err), .order_err(t_order_err)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int n;
    logic [35:0] exp_addr;
    a_in_valid = 0; a_in_time = '0; a_in_cmd = '0; a_in_addr = '0; a_out_ready = 1; a_stop = 0;
    s_in_valid = 0; s_in_time = '0; s_in_cmd = '0; s_in_addr = '0; s_out_ready = 1; s_stop = 0;
    t_in_valid = 0; t_in_time = '0; t_in_cmd = '0; t_in_addr = '0; t_out_ready = 1; t_stop = 0;

    do_reset();
    chk("rst_cycle", 64'(a_cycle), 0);
    chk("rst_level", 64'(a_level), 0);
    chk("rst_out_valid", 64'(a_out_valid), 0);
    chk("rst_in_ready", 64'(a_in_ready), 1);
    chk("rst_idle", 64'(a_idle), 1);
    chk("rst_errs", 64'({a_cmd_err, a_order_err}), 0);
    chk("rst_out_fields", 64'({a_out_time, a_out_addr}), 0);

    // Single timed entry
    tick();
    chk("t1_cycle1", 64'(a_cycle), 1);
    a_in_valid = 1; a_in_time = 32'd5; a_in_cmd = 2'd0; a_in_addr = 36'h1_2345_6789;
    tick();
    a_in_valid = 0;
    chk("t1_level", 64'(a_level), 1);
    chk("t1_not_idle", 64'(a_idle), 0);
    chk("t1_wait_no_valid", 64'(a_out_valid), 0);
    n = 0;
    while (!a_out_valid && n < 20) begin tick(); n++; end
    chk("t1_valid_seen", 64'(a_out_valid), 1);
    chk("t1_valid_cycle", 64'(a_cycle), 6);
    chk("t1_out_addr", 64'(a_out_addr), 64'h1_2345_6789);
    chk("t1_out_time", 64'(a_out_time), 5);
    chk("t1_out_cmd", 64'(a_out_cmd), 0);
    tick();
    chk("t1_popped_valid", 64'(a_out_valid), 0);
    chk("t1_popped_level", 64'(a_level), 0);
    chk("t1_popped_idle", 64'(a_idle), 1);

    // Fill to DEPTH, then push and pop on the same edge
    a_out_ready = 0;
    for (int i = 0; i < 16; i++) begin
      a_in_valid = 1; a_in_time = '0; a_in_cmd = 2'd1; a_in_addr = 36'(i);
      tick();
    end
    a_in_valid = 0;
    chk("t2_full_level", 64'(a_level), 16);
    chk("t2_full_in_ready", 64'(a_in_ready), 0);
    chk("t2_full_out_valid", 64'(a_out_valid), 1);
    chk("t2_full_head", 64'(a_out_addr), 0);
    a_in_valid = 1; a_in_addr = 36'h100; a_out_ready = 1;
    #1;
    chk("t2_ready_on_pop", 64'(a_in_ready), 1);
    tick();
    a_in_valid = 0;
    chk("t2_level_kept", 64'(a_level), 16);
    for (int i = 1; i <= 16; i++) begin
      exp_addr = (i < 16) ? 36'(i) : 36'h100;
      chk("t2_order_valid", 64'(a_out_valid), 1);
      chk("t2_order_addr", 64'(a_out_addr), 64'(exp_addr));
      tick();
    end
    chk("t2_drained_level", 64'(a_level), 0);
    chk("t2_drained_idle", 64'(a_idle), 1);

    // Bad command and out-of-order timestamps
    do_reset();
    a_out_ready = 1;
    a_in_valid = 1; a_in_time = '0; a_in_cmd = 2'd3; a_in_addr = 36'hF;
    tick();
    chk("t3_cmd_err", 64'(a_cmd_err), 1);
    chk("t3_bad_not_stored", 64'(a_level), 0);
    a_in_time = 32'd20; a_in_cmd = 2'd0; a_in_addr = 36'hA;
    tick();
    chk("t3_no_order_err_yet", 64'(a_order_err), 0);
    a_in_time = 32'd10; a_in_cmd = 2'd1; a_in_addr = 36'hB;
    tick();
    a_in_valid = 0;
    chk("t3_order_err", 64'(a_order_err), 1);
    chk("t3_level", 64'(a_level), 2);
    n = 0;
    while (!a_out_valid && n < 40) begin tick(); n++; end
    chk("t3_first_cycle", 64'(a_cycle), 21);
    chk("t3_first_time", 64'(a_out_time), 20);
    chk("t3_first_addr", 64'(a_out_addr), 64'hA);
    tick();
    chk("t3_second_valid", 64'(a_out_valid), 1);
    chk("t3_second_time", 64'(a_out_time), 10);
    chk("t3_second_cycle", 64'(a_cycle), 22);
    tick();
    chk("t3_done_idle", 64'(a_idle), 1);

    // Halt with a presented entry and a backlog
    a_out_ready = 0;
    for (int i = 0; i < 4; i++) begin
      a_in_valid = 1; a_in_time = '0; a_in_cmd = 2'd2; a_in_addr = 36'(i + 32);
      tick();
    end
    a_in_valid = 0;
    chk("t4_level4", 64'(a_level), 4);
    chk("t4_presenting", 64'(a_out_valid), 1);
    a_stop = 1;
    tick();
    a_stop = 0;
    chk("t4_halt_level", 64'(a_level), 0);
    chk("t4_halt_out_valid", 64'(a_out_valid), 0);
    chk("t4_halt_in_ready", 64'(a_in_ready), 0);
    chk("t4_halt_idle", 64'(a_idle), 0);
    chk("t4_halt_cycle", 64'(a_cycle), 27);
    a_in_valid = 1; a_in_time = '0; a_in_cmd = 2'd0;
    tick(); tick(); tick();
    a_in_valid = 0;
    chk("t4_frozen_cycle", 64'(a_cycle), 27);
    chk("t4_halt_no_push", 64'(a_level), 0);
    do_reset();
    chk("t4_reset_cycle", 64'(a_cycle), 0);
    chk("t4_reset_idle", 64'(a_idle), 1);
    chk("t4_reset_in_ready", 64'(a_in_ready), 1);

    // Idle skip on the SKIP_IDLE instance
    tick(); tick();
    chk("t5_cycle2", 64'(s_cycle), 2);
    s_in_valid = 1; s_in_time = 32'd1000; s_in_cmd = 2'd1; s_in_addr = 36'h55;
    tick();
    s_in_valid = 0;
    chk("t5_after_push", 64'(s_cycle), 3);
    tick();
    chk("t5_jump", 64'(s_cycle), 1000);
    chk("t5_not_yet_valid", 64'(s_out_valid), 0);
    tick();
    chk("t5_valid", 64'(s_out_valid), 1);
    chk("t5_valid_cycle", 64'(s_cycle), 1001);
    chk("t5_out_time", 64'(s_out_time), 1000);
    chk("t5_out_cmd", 64'(s_out_cmd), 1);
    tick();
    chk("t5_idle", 64'(s_idle), 1);

    // Counter saturation on the narrow-time instance
    repeat (20) tick();
    chk("t6_saturated", 64'(t_cycle), 15);
    t_in_valid = 1; t_in_time = 4'd15; t_in_cmd = 2'd2; t_in_addr = 36'h7;
    tick();
    t_in_valid = 0;
    chk("t6_still_sat", 64'(t_cycle), 15);
    chk("t6_level", 64'(t_level), 1);
    n = 0;
    while (!t_out_valid && n < 5) begin tick(); n++; end
    chk("t6_valid", 64'(t_out_valid), 1);
    chk("t6_out_time", 64'(t_out_time), 15);
    chk("t6_out_cmd", 64'(t_out_cmd), 2);
    chk("t6_out_addr", 64'(t_out_addr), 7);
    tick();
    chk("t6_idle", 64'(t_idle), 1);
    chk("t6_level0", 64'(t_level), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
